// File: rtl/truth_table_sequencer_pkg.sv
// Shared constants for the truth-table sequencer: FSM encodings and default sizes.
package truth_table_sequencer_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_FIN    = 2'd3;

  localparam int N_IN_DEF   = 3;
  localparam int N_FUNC_DEF = 3;
  localparam int SETTLE_DEF = 1;
endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// Settle counter: counts enabled cycles after a clear and flags the last settle cycle.
module settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign expired = en && (cnt_reg == CNT_LAST);
endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps abc over all input combinations, records gate/operator truth tables
// for the selected function pair and reports the first disagreeing vector.
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int N_FUNC = N_FUNC_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           func_sel,
  output logic [N_IN-1:0]      abc,
  input  logic [N_FUNC-1:0]    y_gate,
  input  logic [N_FUNC-1:0]    y_oper,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [2**N_IN-1:0]   table_gate,
  output logic [2**N_IN-1:0]   table_oper,
  output logic                 mismatch,
  output logic [N_IN-1:0]      first_bad
);
  localparam logic [N_IN-1:0] ABC_LAST = '1;

  logic [1:0]          state_reg;
  logic [1:0]          sel_reg;
  logic [N_IN-1:0]     abc_reg;
  logic [2**N_IN-1:0]  table_gate_reg;
  logic [2**N_IN-1:0]  table_oper_reg;
  logic                mismatch_reg;
  logic [N_IN-1:0]     first_bad_reg;
  logic                err_reg;

  logic start_ok;
  logic g_bit;
  logic o_bit;
  logic timer_clr;
  logic timer_en;
  logic timer_expired;

  assign start_ok = start && (32'(func_sel) < N_FUNC);
  assign g_bit    = y_gate[sel_reg];
  assign o_bit    = y_oper[sel_reg];

  // Counter restarts whenever a fresh abc value is driven.
  assign timer_clr = ((state_reg == ST_IDLE) && start_ok) ||
                     ((state_reg == ST_SAMPLE) && (abc_reg != ABC_LAST));
  assign timer_en  = (state_reg == ST_WAIT);

  settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      sel_reg        <= '0;
      abc_reg        <= '0;
      table_gate_reg <= '0;
      table_oper_reg <= '0;
      mismatch_reg   <= 1'b0;
      first_bad_reg  <= '0;
      err_reg        <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            table_gate_reg <= '0;
            table_oper_reg <= '0;
            mismatch_reg   <= 1'b0;
            first_bad_reg  <= '0;
            abc_reg        <= '0;
            if (start_ok) begin
              sel_reg   <= func_sel;
              err_reg   <= 1'b0;
              state_reg <= ST_WAIT;
            end else begin
              err_reg   <= 1'b1;
              state_reg <= ST_FIN;
            end
          end
        end
        ST_WAIT: begin
          if (timer_expired) begin
            state_reg <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          table_gate_reg[abc_reg] <= g_bit;
          table_oper_reg[abc_reg] <= o_bit;
          if ((g_bit != o_bit) && !mismatch_reg) begin
            mismatch_reg  <= 1'b1;
            first_bad_reg <= abc_reg;
          end
          if (abc_reg == ABC_LAST) begin
            state_reg <= ST_FIN;
          end else begin
            abc_reg   <= abc_reg + 1'b1;
            state_reg <= ST_WAIT;
          end
        end
        default: begin
          abc_reg   <= '0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign abc        = abc_reg;
  assign busy       = (state_reg == ST_WAIT) || (state_reg == ST_SAMPLE);
  assign done       = (state_reg == ST_FIN);
  assign err        = err_reg;
  assign table_gate = table_gate_reg;
  assign table_oper = table_oper_reg;
  assign mismatch   = mismatch_reg;
  assign first_bad  = first_bad_reg;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: one instance with SETTLE=1, one with SETTLE=3.
module tb_truth_table_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start1 = 1'b0;
  logic       start3 = 1'b0;
  logic [1:0] func_sel = 2'd0;

  logic [2:0] abc1, abc3, first_bad1, first_bad3;
  logic [2:0] y_gate1, y_oper1, y_gate3, y_oper3;
  logic       busy1, done1, err1, mismatch1;
  logic       busy3, done3, err3, mismatch3;
  logic [7:0] table_gate1, table_oper1, table_gate3, table_oper3;

  logic       fault_on = 1'b0;
  logic [2:0] fault_abc = 3'd0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // bit0 = AND3, bit1 = XOR3, bit2 = OR3
  function automatic logic [2:0] fmodel(input logic [2:0] v);
    return {|v, ^v, &v};
  endfunction

  always_comb begin
    y_gate1 = fmodel(abc1);
    y_oper1 = fmodel(abc1);
    if (fault_on && (abc1 == fault_abc)) y_oper1 = ~fmodel(abc1);
    y_gate3 = fmodel(abc3);
    y_oper3 = fmodel(abc3);
  end

  truth_table_sequencer #(.SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .func_sel(func_sel), .abc(abc1),
    .y_gate(y_gate1), .y_oper(y_oper1), .busy(busy1), .done(done1), .err(err1),
    .table_gate(table_gate1), .table_oper(table_oper1), .mismatch(mismatch1),
    .first_bad(first_bad1)
  );

  truth_table_sequencer #(.SETTLE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .func_sel(func_sel), .abc(abc3),
    .y_gate(y_gate3), .y_oper(y_oper3), .busy(busy3), .done(done3), .err(err3),
    .table_gate(table_gate3), .table_oper(table_oper3), .mismatch(mismatch3),
    .first_bad(first_bad3)
  );

  // Starts a sweep on instance 1 or 3 and checks abc/busy/done every cycle.
  // pulse_k >= 0 re-asserts start for one cycle mid-sweep.
  task automatic run_sweep(input int which, input logic [1:0] sel, input int settle,
                           input int pulse_k);
    int total;
    logic [2:0] a;
    logic b, d;
    total = 8 * (settle + 1);
    @(negedge clk);
    func_sel = sel;
    if (which == 1) start1 = 1'b1; else start3 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
    for (int k = 0; k < total; k++) begin
      if (k == pulse_k) begin
        if (which == 1) start1 = 1'b1; else start3 = 1'b1;
      end else begin
        start1 = 1'b0;
        start3 = 1'b0;
      end
      a = (which == 1) ? abc1 : abc3;
      b = (which == 1) ? busy1 : busy3;
      d = (which == 1) ? done1 : done3;
      n_checks++;
      if (a !== 3'(k / (settle + 1))) begin
        n_fail++;
        $display("FAIL sweep_abc dut%0d k=%0d: got %0d expected %0d", which, k, a, k / (settle + 1));
      end
      n_checks++;
      if (b !== 1'b1 || d !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep_busy_done dut%0d k=%0d: got busy=%b done=%b expected busy=1 done=0",
                 which, k, b, d);
      end
      @(negedge clk);
    end
    start1 = 1'b0;
    start3 = 1'b0;
    b = (which == 1) ? busy1 : busy3;
    d = (which == 1) ? done1 : done3;
    n_checks++;
    if (d !== 1'b1 || b !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_end dut%0d: got done=%b busy=%b expected done=1 busy=0", which, d, b);
    end
    @(negedge clk);
    a = (which == 1) ? abc1 : abc3;
    d = (which == 1) ? done1 : done3;
    n_checks++;
    if (d !== 1'b0 || a !== 3'd0) begin
      n_fail++;
      $display("FAIL sweep_after dut%0d: got done=%b abc=%0d expected done=0 abc=0", which, d, a);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    n_checks++;
    if ({abc1, busy1, done1, err1, table_gate1, table_oper1, mismatch1, first_bad1} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut1: got abc=%0d busy=%b done=%b err=%b tg=%h to=%h mm=%b fb=%0d expected all 0",
               abc1, busy1, done1, err1, table_gate1, table_oper1, mismatch1, first_bad1);
    end
    n_checks++;
    if ({abc3, busy3, done3, err3, table_gate3, table_oper3, mismatch3, first_bad3} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut3: got abc=%0d busy=%b done=%b err=%b tg=%h to=%h expected all 0",
               abc3, busy3, done3, err3, table_gate3, table_oper3);
    end
    @(negedge clk);
    reset = 1'b0;
    $display("reset: outputs cleared on both instances");
  endtask

  task automatic test_and3();
    run_sweep(1, 2'd0, 1, -1);
    n_checks++;
    if (table_gate1 !== 8'h80 || table_oper1 !== 8'h80) begin
      n_fail++;
      $display("FAIL and3_tables: got tg=%h to=%h expected 80/80", table_gate1, table_oper1);
    end
    n_checks++;
    if (mismatch1 !== 1'b0 || err1 !== 1'b0) begin
      n_fail++;
      $display("FAIL and3_flags: got mismatch=%b err=%b expected 0/0", mismatch1, err1);
    end
    $display("and3 sweep: tg=%h to=%h mismatch=%b", table_gate1, table_oper1, mismatch1);
  endtask

  task automatic test_xor3_fault();
    fault_on  = 1'b1;
    fault_abc = 3'd5;
    run_sweep(1, 2'd1, 1, -1);
    fault_on = 1'b0;
    n_checks++;
    if (table_gate1 !== 8'h96 || table_oper1 !== 8'hB6) begin
      n_fail++;
      $display("FAIL xor3_tables: got tg=%h to=%h expected 96/b6", table_gate1, table_oper1);
    end
    n_checks++;
    if (mismatch1 !== 1'b1 || first_bad1 !== 3'd5) begin
      n_fail++;
      $display("FAIL xor3_first_bad: got mismatch=%b first_bad=%0d expected 1/5", mismatch1, first_bad1);
    end
    $display("xor3 fault sweep: tg=%h to=%h first_bad=%0d", table_gate1, table_oper1, first_bad1);
  endtask

  task automatic test_bad_sel();
    @(negedge clk);
    func_sel = 2'd3;
    start1   = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n_checks++;
    if (err1 !== 1'b1 || done1 !== 1'b1 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_sel_flags: got err=%b done=%b busy=%b expected 1/1/0", err1, done1, busy1);
    end
    n_checks++;
    if (table_gate1 !== 8'h00 || table_oper1 !== 8'h00 || abc1 !== 3'd0 || mismatch1 !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_sel_tables: got tg=%h to=%h abc=%0d mm=%b expected 00/00/0/0",
               table_gate1, table_oper1, abc1, mismatch1);
    end
    @(negedge clk);
    n_checks++;
    if (done1 !== 1'b0 || err1 !== 1'b1 || busy1 !== 1'b0 || abc1 !== 3'd0) begin
      n_fail++;
      $display("FAIL bad_sel_hold: got done=%b err=%b busy=%b abc=%0d expected 0/1/0/0",
               done1, err1, busy1, abc1);
    end
    $display("bad func_sel=3: err=%b tg=%h", err1, table_gate1);
  endtask

  task automatic test_restart_ignored();
    // abc reaches 3 at k=6; start re-asserted there must not disturb the sweep
    run_sweep(1, 2'd0, 1, 6);
    n_checks++;
    if (table_gate1 !== 8'h80 || err1 !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_tables: got tg=%h err=%b expected 80/0", table_gate1, err1);
    end
    $display("mid-sweep start ignored: tg=%h", table_gate1);
  endtask

  task automatic test_reset_mid_sweep();
    @(negedge clk);
    func_sel = 2'd0;
    start1   = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++;
    if (abc1 !== 3'd4) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got abc=%0d expected 4", abc1);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({abc1, busy1, done1, err1, table_gate1, table_oper1, mismatch1, first_bad1} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got abc=%0d busy=%b tg=%h to=%h expected all 0",
               abc1, busy1, table_gate1, table_oper1);
    end
    @(negedge clk);
    reset = 1'b0;
    run_sweep(1, 2'd0, 1, -1);
    n_checks++;
    if (table_gate1 !== 8'h80 || table_oper1 !== 8'h80) begin
      n_fail++;
      $display("FAIL reset_mid_resweep: got tg=%h to=%h expected 80/80", table_gate1, table_oper1);
    end
    $display("reset mid-sweep then full sweep: tg=%h", table_gate1);
  endtask

  task automatic test_settle3_or3();
    run_sweep(3, 2'd2, 3, -1);
    n_checks++;
    if (table_gate3 !== 8'hFE || table_oper3 !== 8'hFE || mismatch3 !== 1'b0) begin
      n_fail++;
      $display("FAIL or3_settle3: got tg=%h to=%h mm=%b expected fe/fe/0",
               table_gate3, table_oper3, mismatch3);
    end
    $display("or3 settle=3 sweep: tg=%h to=%h", table_gate3, table_oper3);
  endtask

  initial begin
    test_reset();
    test_and3();
    test_xor3_fault();
    test_bad_sel();
    test_restart_ignored();
    test_reset_mid_sweep();
    test_settle3_or3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
